// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the D-stage hazard controller.
// Holds TUSE/TNEW codes, the MDU state enum and default cycle counts.
package hazard_pkg;

    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // One source operand against the producers in E and M.
    function automatic logic src_hazard(
        input logic [4:0] addr,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        logic w_e;
        logic w_m;
        w_e = (addr == e_wa) && (tuse < e_tnew);
        w_m = (addr == m_wa) && (tuse < m_tnew);
        return (tuse != TUSE_NONE) && (addr != 5'd0)
            && (w_e || w_m);
    endfunction

endpackage

// File: rtl/md_timer.sv
// MDU occupancy sequencer: counts E-stage busy cycles for mult/div
// and pulses done on the last busy cycle.
module md_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    md_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] w_load;

    assign w_load = i_is_div ? DIV_LD : MULT_LD;

    // done is registered one cycle early so it lands on cnt == 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= BUSY;
                        r_cnt   <= w_load;
                        r_busy  <= 1'b1;
                        r_done  <= (w_load == CNT_W'(1));
                    end
                end
                BUSY: begin
                    r_cnt  <= r_cnt - CNT_W'(1);
                    r_done <= (r_cnt == CNT_W'(2));
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/md_hazard_ctrl.sv
// D-stage stall/flush controller: register hazards against E/M
// plus MDU occupancy hazards, driving F/D hold and D/E bubble.
module md_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic       D_is_md,
    input  logic [4:0] E_wa,
    input  logic [4:0] M_wa,
    input  logic [1:0] E_tnew,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       stall,
    output logic       d2e_clear,
    output logic       md_busy,
    output logic       md_done,
    output logic       hilo_we
);

    logic             w_rs_hz;
    logic             w_rt_hz;
    logic             w_md_hz;
    logic             w_hz;
    logic             w_busy;
    logic             w_done;
    logic [CNT_W-1:0] w_cnt;

    md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_timer (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_start  (E_md_start),
        .i_is_div (E_md_is_div),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_cnt    (w_cnt)
    );

    assign w_rs_hz = src_hazard(D_rs_addr, D_rs_tuse,
                                E_wa, E_tnew, M_wa, M_tnew);
    assign w_rt_hz = src_hazard(D_rt_addr, D_rt_tuse,
                                E_wa, E_tnew, M_wa, M_tnew);
    assign w_md_hz = D_is_md && (w_busy || E_md_start);

    // All hazard sources collapse into one stall; reset masks it.
    assign w_hz = reset && (w_rs_hz || w_rt_hz || w_md_hz);

    assign stall     = w_hz;
    assign d2e_clear = w_hz;
    assign md_busy   = w_busy;
    assign md_done   = w_done;
    assign hilo_we   = w_done;

    logic w_unused;
    assign w_unused = ^w_cnt;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed bench for md_hazard_ctrl: vector table for the
// combinational hazards plus MDU timeline and reset sequences.
module tb_md_hazard_ctrl;

    localparam int NM = 5;
    localparam int ND = 10;
    localparam logic [1:0] NONE = 2'd3;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs_addr, D_rt_addr;
    logic [1:0] D_rs_tuse, D_rt_tuse;
    logic       D_is_md;
    logic [4:0] E_wa, M_wa;
    logic [1:0] E_tnew, M_tnew;
    logic       E_md_start, E_md_is_div;
    logic       stall, d2e_clear, md_busy, md_done, hilo_we;

    int checks = 0;
    int errors = 0;

    md_hazard_ctrl #(
        .MULT_CYCLES (NM),
        .DIV_CYCLES  (ND)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs_addr   (D_rs_addr),
        .D_rt_addr   (D_rt_addr),
        .D_rs_tuse   (D_rs_tuse),
        .D_rt_tuse   (D_rt_tuse),
        .D_is_md     (D_is_md),
        .E_wa        (E_wa),
        .M_wa        (M_wa),
        .E_tnew      (E_tnew),
        .M_tnew      (M_tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .stall       (stall),
        .d2e_clear   (d2e_clear),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .hilo_we     (hilo_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (reset && E_md_start && md_busy) begin
            errors++;
            $display("FAIL illegal_start: got start while busy expected none");
        end
    end

    typedef struct {
        logic [4:0] rs;
        logic [1:0] rs_tu;
        logic [4:0] rt;
        logic [1:0] rt_tu;
        logic       is_md;
        logic [4:0] ewa;
        logic [1:0] etn;
        logic [4:0] mwa;
        logic [1:0] mtn;
        logic       exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        D_rs_addr = 0; D_rt_addr = 0;
        D_rs_tuse = NONE; D_rt_tuse = NONE;
        D_is_md = 0;
        E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
        E_md_start = 0; E_md_is_div = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input logic is_div, input int n,
                          input string tag);
        next_cyc();
        idle_in();
        E_md_start = 1; E_md_is_div = is_div; D_is_md = 1;
        @(negedge clk);
        chk({tag, "_c0_stall"}, {7'd0, stall}, 8'd1);
        chk({tag, "_c0_busy"}, {7'd0, md_busy}, 8'd0);
        for (int c = 1; c <= n + 1; c++) begin
            next_cyc();
            E_md_start = 0;
            @(negedge clk);
            chk($sformatf("%s_c%0d_busy", tag, c),
                {7'd0, md_busy}, {7'd0, c <= n});
            chk($sformatf("%s_c%0d_done", tag, c),
                {7'd0, md_done}, {7'd0, c == n});
            chk($sformatf("%s_c%0d_hilo", tag, c),
                {7'd0, hilo_we}, {7'd0, c == n});
            chk($sformatf("%s_c%0d_stall", tag, c),
                {7'd0, stall}, {7'd0, c <= n});
        end
        next_cyc();
        idle_in();
    endtask

    initial begin
        //          rs rsT rt rtT md ewa etn mwa mtn exp
        vecs[0]  = '{0, NONE, 0, NONE, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{8, 1, 0, NONE, 0, 8, 2, 0, 0, 1};
        vecs[2]  = '{8, 1, 0, NONE, 0, 0, 0, 8, 1, 0};
        vecs[3]  = '{0, 0, 0, NONE, 0, 0, 2, 0, 0, 0};
        vecs[4]  = '{8, NONE, 0, NONE, 0, 8, 2, 0, 0, 0};
        vecs[5]  = '{0, NONE, 5, 0, 0, 0, 0, 5, 1, 1};
        vecs[6]  = '{0, NONE, 5, 1, 0, 5, 1, 0, 0, 0};
        vecs[7]  = '{9, 0, 0, NONE, 0, 9, 1, 0, 0, 1};
        vecs[8]  = '{7, 0, 0, NONE, 0, 8, 2, 0, 0, 0};
        vecs[9]  = '{8, 2, 0, NONE, 0, 8, 2, 0, 0, 0};
        vecs[10] = '{0, NONE, 0, NONE, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{3, 0, 4, 1, 0, 3, 1, 4, 2, 1};

        reset = 0;
        idle_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {7'd0, md_busy}, 8'd0);
        chk("rst_done", {7'd0, md_done}, 8'd0);
        chk("rst_hilo", {7'd0, hilo_we}, 8'd0);
        chk("rst_stall", {7'd0, stall}, 8'd0);
        chk("rst_cnt", {4'd0, dut.u_timer.r_cnt}, 8'd0);
        D_rs_addr = 8; D_rs_tuse = 1; E_wa = 8; E_tnew = 2;
        #1;
        chk("rst_mask_stall", {7'd0, stall}, 8'd0);
        chk("rst_mask_clr", {7'd0, d2e_clear}, 8'd0);

        next_cyc();
        reset = 1;
        idle_in();

        for (int i = 0; i < 12; i++) begin
            next_cyc();
            D_rs_addr = vecs[i].rs; D_rs_tuse = vecs[i].rs_tu;
            D_rt_addr = vecs[i].rt; D_rt_tuse = vecs[i].rt_tu;
            D_is_md = vecs[i].is_md;
            E_wa = vecs[i].ewa; E_tnew = vecs[i].etn;
            M_wa = vecs[i].mwa; M_tnew = vecs[i].mtn;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i),
                {7'd0, stall}, {7'd0, vecs[i].exp});
            chk($sformatf("vec%0d_clr", i),
                {7'd0, d2e_clear}, {7'd0, vecs[i].exp});
        end

        // Load-use: one bubble, then the producer is in M.
        next_cyc();
        idle_in();
        E_wa = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1;
        @(negedge clk);
        chk("lu_c0_stall", {7'd0, stall}, 8'd1);
        chk("lu_c0_clr", {7'd0, d2e_clear}, 8'd1);
        next_cyc();
        E_wa = 0; E_tnew = 0; M_wa = 8; M_tnew = 1;
        @(negedge clk);
        chk("lu_c1_stall", {7'd0, stall}, 8'd0);
        chk("lu_c1_clr", {7'd0, d2e_clear}, 8'd0);

        run_md(1'b0, NM, "mult");
        run_md(1'b1, ND, "div");

        // Reset asserted mid-div.
        next_cyc();
        idle_in();
        E_md_start = 1; E_md_is_div = 1; D_is_md = 1;
        for (int c = 1; c <= 12; c++) begin
            next_cyc();
            E_md_start = 0;
            if (c == 3) begin
                reset = 0;
                D_rs_addr = 8; D_rs_tuse = 0; E_wa = 8; E_tnew = 1;
            end
            if (c == 7) begin
                reset = 1;
                idle_in();
            end
            @(negedge clk);
            chk($sformatf("rd_c%0d_done", c), {7'd0, md_done}, 8'd0);
            chk($sformatf("rd_c%0d_hilo", c), {7'd0, hilo_we}, 8'd0);
            if (c <= 3)
                chk($sformatf("rd_c%0d_busy", c), {7'd0, md_busy}, 8'd1);
            else
                chk($sformatf("rd_c%0d_busy", c), {7'd0, md_busy}, 8'd0);
            if (c >= 3 && c <= 6)
                chk($sformatf("rd_c%0d_stall", c), {7'd0, stall}, 8'd0);
            if (c == 4)
                chk("rd_c4_cnt", {4'd0, dut.u_timer.r_cnt}, 8'd0);
        end

        // rt hazard and MDU hazard overlapping; rt held through c6.
        next_cyc();
        idle_in();
        E_md_start = 1; D_is_md = 1;
        D_rt_addr = 9; D_rt_tuse = 0; M_wa = 9; M_tnew = 1;
        @(negedge clk);
        chk("cmb_c0_stall", {7'd0, stall}, 8'd1);
        for (int c = 1; c <= 8; c++) begin
            next_cyc();
            E_md_start = 0;
            if (c == 7) begin
                M_wa = 0; M_tnew = 0;
            end
            @(negedge clk);
            chk($sformatf("cmb_c%0d_stall", c),
                {7'd0, stall}, {7'd0, c <= 6});
            chk($sformatf("cmb_c%0d_clr", c),
                {7'd0, d2e_clear}, {7'd0, c <= 6});
        end

        // MDU clears first while rt hazard persists.
        next_cyc();
        idle_in();
        E_md_start = 1; D_is_md = 1;
        D_rt_addr = 9; D_rt_tuse = 0; E_wa = 9; E_tnew = 1;
        for (int c = 1; c <= 7; c++) begin
            next_cyc();
            E_md_start = 0;
            @(negedge clk);
            chk($sformatf("cmb2_c%0d_stall", c), {7'd0, stall}, 8'd1);
        end
        next_cyc();
        E_wa = 0; E_tnew = 0;
        @(negedge clk);
        chk("cmb2_end_stall", {7'd0, stall}, 8'd0);
        chk("cmb2_end_busy", {7'd0, md_busy}, 8'd0);

        next_cyc();
        idle_in();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
